// File: rtl/regfile_alu_core.sv
// regfile_alu_core: handshaked register file + ALU + sequencing FSM (IDLE/READ/EXEC/WB/RESP).
// Define ALU_CARRY_CHAIN_EN to add the ADC (1110) and SBC (1111) opcodes.
module regfile_alu_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int CMD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CMD_WIDTH-1:0]  instr,
  input  logic [ADDR_WIDTH-1:0] rs_a,
  input  logic [ADDR_WIDTH-1:0] rs_b,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_flag,
  output logic                  carry,
  output logic [2:0]            dbg_state
);
  localparam int W = DATA_WIDTH;
  localparam int N = 2**ADDR_WIDTH;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    RESP = 3'd4
  } state_t;
  state_t                r_state, w_next;
  logic [3:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_rs_a, r_rs_b, r_rd;
  logic [W-1:0]          r_data, r_a, r_b, r_res, r_out_data;
  logic                  r_flag, r_carry, r_out_flag;
  logic [W-1:0]          r_rf [N];
  logic [W-1:0]          w_res;
  logic                  w_flag, w_def, w_wr, w_uc;
  logic [W:0]            w_add, w_sub;
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
`ifdef ALU_CARRY_CHAIN_EN
  logic [W:0] w_adc, w_sbc;
  assign w_adc = w_add + {{W{1'b0}}, r_carry};
  assign w_sbc = w_sub - {{W{1'b0}}, r_carry};
`endif
  always_comb begin
    w_res  = '0;
    w_flag = 1'b0;
    w_def  = 1'b1;
    case (r_op)
      4'b0000: w_res = '0;
      4'b0001: w_res = ~r_a;
      4'b0010: begin w_res = {r_a[W-2:0], 1'b0}; w_flag = r_a[W-1]; end
      4'b0011: begin w_res = {1'b0, r_a[W-1:1]}; w_flag = r_a[0]; end
      4'b0100: begin w_res = {r_carry, r_a[W-1:1]}; w_flag = r_a[0]; end
      4'b0101: w_res = r_data;
      4'b1001: w_res = r_a & r_b;
      4'b1010: w_res = r_a | r_b;
      4'b1011: {w_flag, w_res} = w_add;
      4'b1100: {w_flag, w_res} = w_sub;
      4'b1101: w_res = r_a ^ r_b;
`ifdef ALU_CARRY_CHAIN_EN
      4'b1110: {w_flag, w_res} = w_adc;
      4'b1111: {w_flag, w_res} = w_sbc;
`endif
      default: w_def = 1'b0;
    endcase
  end
  // NOP and undefined opcodes leave the file alone; LOAD writes but keeps carry.
  assign w_wr = w_def & (r_op != 4'b0000);
  assign w_uc = w_wr & (r_op != 4'b0101);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? READ : IDLE;
      READ:    w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = RESP;
      RESP:    w_next = out_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_rs_a     <= '0;
      r_rs_b     <= '0;
      r_rd       <= '0;
      r_data     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_flag     <= 1'b0;
      r_carry    <= 1'b0;
      r_out_data <= '0;
      r_out_flag <= 1'b0;
      r_rf       <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_op   <= instr[3:0];
        r_rs_a <= rs_a;
        r_rs_b <= rs_b;
        r_rd   <= rd;
        r_data <= data;
      end
      if (r_state == READ) begin
        r_a <= r_rf[r_rs_a];
        r_b <= r_rf[r_rs_b];
      end
      if (r_state == EXEC) begin
        r_res  <= w_res;
        r_flag <= w_flag;
      end
      if (r_state == WB) begin
        if (w_wr) r_rf[r_rd] <= r_res;
        if (w_uc) r_carry <= r_flag;
        r_out_data <= r_res;
        r_out_flag <= r_flag;
      end
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == RESP);
  assign out_data  = r_out_data;
  assign out_flag  = r_out_flag;
  assign carry     = r_carry;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_regfile_alu_core.sv
// tb_regfile_alu_core: directed and randomized checks of regfile_alu_core against an arithmetic model.
module tb_regfile_alu_core;
  logic       clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, out_flag, carry;
  logic [3:0] instr = '0;
  logic [1:0] rs_a = '0, rs_b = '0, rd = '0;
  logic [7:0] data = '0, out_data;
  logic [2:0] dbg_state;
  int         n_cmp = 0, n_err = 0;
  logic [7:0] m_rf [4];
  logic       m_carry;
  localparam logic [3:0] NOP = 4'b0000, RCSHIFT = 4'b0100, LOAD = 4'b0101, LOR = 4'b1010,
                         ADD = 4'b1011, SUB = 4'b1100;
  always #5 clk = ~clk;
  regfile_alu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CMD_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .data(data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flag(out_flag), .carry(carry), .dbg_state(dbg_state)
  );
  function automatic void model(input logic [3:0] op, input int a, input int b, input int d, input int c,
                                output int res, output bit fl, output bit wr, output bit uc);
    res = 0; fl = 1'b0; wr = 1'b1; uc = 1'b1;
    case (op)
      4'd1:  res = 255 - a;
      4'd2:  begin res = (a * 2) % 256; fl = a >= 128; end
      4'd3:  begin res = a / 2; fl = (a % 2) == 1; end
      4'd4:  begin res = c * 128 + a / 2; fl = (a % 2) == 1; end
      4'd5:  begin res = d; uc = 1'b0; end
      4'd9:  res = a & b;
      4'd10: res = a | b;
      4'd11: begin res = (a + b) % 256; fl = (a + b) >= 256; end
      4'd12: begin res = (a - b + 256) % 256; fl = a < b; end
      4'd13: res = a ^ b;
`ifdef ALU_CARRY_CHAIN_EN
      4'd14: begin res = (a + b + c) % 256; fl = (a + b + c) >= 256; end
      4'd15: begin res = (a - b - c + 512) % 256; fl = a < (b + c); end
`endif
      default: begin wr = 1'b0; uc = 1'b0; end
    endcase
  endfunction
  task automatic apply(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                       input logic [7:0] imm, output logic [7:0] er, output logic ef);
    int res; bit fl, wr, uc;
    model(op, int'(m_rf[a]), int'(m_rf[b]), int'(imm), int'(m_carry), res, fl, wr, uc);
    er = res[7:0];
    ef = fl;
    if (wr) m_rf[d] = res[7:0];
    if (uc) m_carry = fl;
  endtask
  task automatic issue(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                       input logic [7:0] imm, input int hold, output logic [7:0] od, output logic of, output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    in_valid = 1'b1; instr = op; rs_a = a; rs_b = b; rd = d; data = imm;
    @(negedge clk);
    in_valid = 1'b0; instr = 4'($urandom); rs_a = 2'($urandom); rs_b = 2'($urandom);
    rd = 2'($urandom); data = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    od = out_data;
    of = out_flag;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  // Issue an op and advance the model; returns DUT result and model expectation.
  task automatic do_op(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                       input logic [7:0] imm, input int hold, output logic [7:0] od, output logic of,
                       output logic [7:0] er, output logic ef, output int lat);
    issue(op, a, b, d, imm, hold, od, of, lat);
    apply(op, a, b, d, imm, er, ef);
  endtask
  task automatic read_reg(input logic [1:0] idx, output logic [7:0] od, output logic [7:0] er);
    logic of, ef; int lat;
    do_op(LOR, idx, idx, idx, 8'h00, 0, od, of, er, ef, lat);
  endtask
  task automatic test_reset;
    logic [7:0] od, er;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    foreach (m_rf[i]) m_rf[i] = 8'h00;
    m_carry = 1'b0;
    n_cmp++; if ({in_ready, out_valid, carry, out_flag} !== 4'b1000) begin n_err++; $display("FAIL reset_ctl: got rdy/val/carry/flag=%b want 1000", {in_ready, out_valid, carry, out_flag}); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), od, er);
      n_cmp++; if (od !== 8'h00) begin n_err++; $display("FAIL reset_r%0d: got %h want 00", i, od); end
    end
  endtask
  task automatic test_add;
    logic [7:0] od, er; logic of, ef; int lat;
    do_op(LOAD, 0, 0, 1, 8'h3C, 0, od, of, er, ef, lat);
    do_op(LOAD, 0, 0, 2, 8'hC5, 0, od, of, er, ef, lat);
    do_op(ADD, 1, 2, 0, 8'h00, 0, od, of, er, ef, lat);
    n_cmp++; if ({of, od} !== 9'h101) begin n_err++; $display("FAIL add_result: got flag=%b data=%h want 1/01", of, od); end
    n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL add_carry: got %b want 1", carry); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d want 4", lat); end
    read_reg(0, od, er);
    n_cmp++; if (od !== 8'h01) begin n_err++; $display("FAIL add_r0: got %h want 01", od); end
  endtask
  task automatic test_sub;
    logic [7:0] od, er; logic of, ef; int lat;
    do_op(LOAD, 0, 0, 1, 8'h05, 0, od, of, er, ef, lat);
    do_op(LOAD, 0, 0, 2, 8'h07, 0, od, of, er, ef, lat);
    do_op(SUB, 1, 2, 3, 8'h00, 1, od, of, er, ef, lat);
    n_cmp++; if ({of, od, carry} !== {1'b1, 8'hFE, 1'b1}) begin n_err++; $display("FAIL sub_borrow: got flag=%b data=%h carry=%b want 1/fe/1", of, od, carry); end
    do_op(SUB, 2, 1, 3, 8'h00, 0, od, of, er, ef, lat);
    n_cmp++; if ({of, od, carry} !== {1'b0, 8'h02, 1'b0}) begin n_err++; $display("FAIL sub_plain: got flag=%b data=%h carry=%b want 0/02/0", of, od, carry); end
    read_reg(3, od, er);
    n_cmp++; if (od !== 8'h02) begin n_err++; $display("FAIL sub_r3: got %h want 02", od); end
  endtask
  task automatic test_rcshift;
    logic [7:0] od, er; logic of, ef; int lat;
    do_op(LOAD, 0, 0, 1, 8'hFF, 0, od, of, er, ef, lat);
    do_op(ADD, 1, 1, 3, 8'h00, 0, od, of, er, ef, lat);
    do_op(LOAD, 0, 0, 1, 8'h02, 0, od, of, er, ef, lat);
    n_cmp++; if (carry !== 1'b1) begin n_err++; $display("FAIL load_keeps_carry: got %b want 1", carry); end
    do_op(RCSHIFT, 1, 0, 1, 8'h00, 0, od, of, er, ef, lat);
    n_cmp++; if ({of, od, carry} !== {1'b0, 8'h81, 1'b0}) begin n_err++; $display("FAIL rcshift: got flag=%b data=%h carry=%b want 0/81/0", of, od, carry); end
    read_reg(1, od, er);
    n_cmp++; if (od !== 8'h81) begin n_err++; $display("FAIL rcshift_r1: got %h want 81", od); end
  endtask
  task automatic test_backpressure;
    logic [7:0] od, er, held; logic of, ef; int lat, n, bad;
    do_op(LOAD, 0, 0, 2, 8'h5A, 0, od, of, er, ef, lat);
    @(negedge clk);
    in_valid = 1'b1; instr = LOR; rs_a = 2; rs_b = 2; rd = 0; data = 8'h00;
    @(negedge clk);
    apply(LOR, 2, 2, 0, 8'h00, er, ef);
    instr = LOAD; rd = 2; data = 8'hAA;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    held = out_data;
    n_cmp++; if (held !== 8'h5A) begin n_err++; $display("FAIL bp_data: got %h want 5a", held); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({out_valid, in_ready, out_data, dbg_state} !== {1'b1, 1'b0, held, 3'd4}) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if ({dbg_state, in_ready, out_valid} !== {3'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL bp_release: got state=%0d rdy=%b val=%b want 0/1/0", dbg_state, in_ready, out_valid); end
    in_valid = 1'b0;
    read_reg(2, od, er);
    n_cmp++; if (od !== 8'h5A) begin n_err++; $display("FAIL bp_no_accept: got r2=%h want 5a", od); end
  endtask
  task automatic test_reset_abort;
    logic [7:0] od, er; logic of, ef; int lat, n;
    do_op(LOAD, 0, 0, 1, 8'hFF, 0, od, of, er, ef, lat);
    do_op(LOAD, 0, 0, 2, 8'h01, 0, od, of, er, ef, lat);
    @(negedge clk);
    in_valid = 1'b1; instr = ADD; rs_a = 1; rs_b = 2; rd = 0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (dbg_state !== 3'd2 && n < 10) begin @(negedge clk); n++; end
    n_cmp++; if (dbg_state !== 3'd2) begin n_err++; $display("FAIL abort_exec: got state=%0d want 2", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    foreach (m_rf[i]) m_rf[i] = 8'h00;
    m_carry = 1'b0;
    n_cmp++; if ({out_valid, in_ready, carry} !== 3'b010) begin n_err++; $display("FAIL abort_ctl: got val/rdy/carry=%b want 010", {out_valid, in_ready, carry}); end
    read_reg(0, od, er);
    n_cmp++; if (od !== 8'h00) begin n_err++; $display("FAIL abort_r0: got %h want 00", od); end
  endtask
  task automatic test_undef_or_chain;
    logic [7:0] od, er; logic of, ef; int lat;
    do_op(LOAD, 0, 0, 2, 8'h77, 0, od, of, er, ef, lat);
    do_op(LOAD, 0, 0, 1, 8'hFF, 0, od, of, er, ef, lat);
    do_op(ADD, 1, 1, 3, 8'h00, 0, od, of, er, ef, lat);
    do_op(LOAD, 0, 0, 0, 8'h10, 0, od, of, er, ef, lat);
    do_op(LOAD, 0, 0, 1, 8'h20, 0, od, of, er, ef, lat);
    do_op(4'b1110, 0, 1, 2, 8'h00, 0, od, of, er, ef, lat);
    n_cmp++; if ({of, od, carry} !== {ef, er, m_carry}) begin n_err++; $display("FAIL op1110: got flag=%b data=%h carry=%b want %b/%h/%b", of, od, carry, ef, er, m_carry); end
    do_op(4'b0110, 0, 1, 3, 8'h00, 0, od, of, er, ef, lat);
    n_cmp++; if ({of, od, carry} !== {1'b0, 8'h00, m_carry}) begin n_err++; $display("FAIL op0110: got flag=%b data=%h carry=%b want 0/00/%b", of, od, carry, m_carry); end
    read_reg(2, od, er);
    n_cmp++; if (od !== er) begin n_err++; $display("FAIL op1110_r2: got %h want %h", od, er); end
  endtask
  task automatic test_random;
    logic [7:0] od, er; logic of, ef; int lat, bad;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      do_op(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), $urandom_range(0, 3),
            od, of, er, ef, lat);
      n_cmp++; if ({of, od, carry} !== {ef, er, m_carry} || lat !== 4) begin n_err++; $display("FAIL random_%0d: got flag=%b data=%h carry=%b lat=%0d want %b/%h/%b/4", i, of, od, carry, lat, ef, er, m_carry); end
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), od, er);
      n_cmp++; if (od !== er) begin n_err++; $display("FAIL random_r%0d: got %h want %h", i, od, er); end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] od, er; logic of, ef; int lat;
    do_op(LOAD, 0, 0, 3, 8'h80, 0, od, of, er, ef, lat);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    do_op(NOP, 3, 3, 3, 8'h00, 0, od, of, er, ef, lat);
    do_op(4'b0010, 3, 0, 3, 8'h00, 0, od, of, er, ef, lat);
    n_cmp++; if ({of, od, carry} !== {1'b1, 8'h00, 1'b1}) begin n_err++; $display("FAIL b2b_lshift: got flag=%b data=%h carry=%b want 1/00/1", of, od, carry); end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_rcshift;
    test_backpressure;
    test_reset_abort;
    test_undef_or_chain;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
